apbspi_sclk_ctrl: RTL and testbench
===================================

Name: apbspi_sclk_ctrl

Overview:
- Sequencer for the SPI serial-clock resource of the APB SPI core.
- On a start request it latches the divider, mode (CPOL/CPHA) and bit count.
- It generates SCLK and the chip-select window, and issues one-cycle sample/shift strobes to the shift-register datapath.
- It reports busy/done back to the APB register file; it is the only block that owns SCLK timing.

Parameters:
- DIV_W, 8, width of the half-period divider value.
- LEN_W, 5, width of the bit-count field; a transfer carries len+1 bits (1..2^LEN_W).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transfer request; honoured only when busy=0.
- abort  input  1  terminate the current transfer.
- div  input  DIV_W  half-period of SCLK minus one, in clk cycles.
- len  input  LEN_W  bits per transfer minus one.
- cpol  input  1  SCLK idle level.
- cpha  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- sclk  output  1  SPI serial clock, registered.
- cs_n  output  1  chip select, active low, registered.
- sample_en  output  1  one-cycle strobe: datapath captures MISO.
- shift_en  output  1  one-cycle strobe: datapath advances MOSI.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, sclk=0, cs_n=1, sample_en=0, shift_en=0, busy=0, done=0, all counters 0.
- States: IDLE and RUN.

IDLE:
- sclk tracks cpol (registered, one-cycle lag).
- cs_n=1, busy=0.
- start=1 at edge k:
  - latch div, len, cpol, cpha.
  - hcnt<=0, ecnt<=0.
  - busy<=1, cs_n<=0, state<=RUN.

RUN:
- Per cycle: if hcnt==div_l, hcnt<=0 and an SCLK edge occurs; else hcnt<=hcnt+1.
- On an SCLK edge:
  - sclk<=~sclk, ecnt<=ecnt+1.
  - Odd edges (1,3,..) are leading, even edges are trailing.
- Strobes are registered together with the sclk toggle, so they are high in the same cycle sclk shows its new level.
- CPHA=0: sample_en on each leading edge; shift_en on each trailing edge except the final one.
- CPHA=1: shift_en on each leading edge, including the first; sample_en on each trailing edge.
- Edges occur at clock edges k+(div+1)*n, n=1..2*(len+1).
- On the final edge (ecnt reaches 2*(len+1)):
  - busy<=0, cs_n<=1, done<=1, state<=IDLE.
  - sclk returns to cpol_l, which is automatic: an even number of toggles.
- done is high for exactly one cycle.

Widths:
- hcnt is DIV_W bits.
- ecnt is LEN_W+2 bits, which holds 2^(LEN_W+1) without wrap.

Boundaries:
- div=0: SCLK toggles every clk cycle (SCLK = clk/2).
- div=2^DIV_W-1: half-period of 2^DIV_W cycles with no counter overflow.
- len=2^LEN_W-1: 2^LEN_W bits.
- start while busy=1: ignored, no re-latch.
- div/len/cpol/cpha changes while busy: ignored until the next start.
- abort in RUN:
  - next edge: state<=IDLE, busy<=0, cs_n<=1, sclk<=cpol_l.
  - strobes forced 0, done stays 0.
  - abort has priority over an SCLK edge in the same cycle.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start is ignored.
- rst_n asserted mid-transfer: immediate return to the reset values, no done.

Test Plan:
- Basic CPHA=0: rst, then div=1, len=1, cpol=0, cpha=0, start at edge k.
  - sclk rises at k+2 and k+6, falls at k+4 and k+8.
  - sample_en at k+2 and k+6; shift_en at k+4 only.
  - done=1 and busy=0 at k+8; cs_n low from k to k+7.
- CPHA=1/CPOL=1: div=0, len=2.
  - sclk idles 1 and toggles every cycle for 6 edges.
  - shift_en on edges 1, 3, 5; sample_en on edges 2, 4, 6.
  - sclk=1 after done.
- Max config: div=255, len=31.
  - 64 edges spaced 256 cycles apart.
  - busy high for exactly 16384 cycles; single done pulse.
- Ignored start: a second start with different div mid-transfer.
  - edge spacing unchanged, one done only.
  - a new start the cycle after done is accepted.
- Abort: abort after edge 3 of an 8-bit transfer.
  - next cycle: busy=0, cs_n=1, sclk=cpol, no strobes, done never asserted.
  - a following start runs a full transfer.
- Async reset: drop rst_n between clk edges mid-transfer.
  - all outputs go to reset values immediately, without a clk edge.
  - after release, a start works normally.

Source files
------------

// File: rtl/apbspi_sclk_ctrl.sv
// SPI serial-clock sequencer: latches divider/mode/length on start, drives SCLK, CS_n and sample/shift strobes.
// Latency: first SCLK edge (div+1) clk cycles after the accepting edge; done pulses on the final edge.
// Backpressure: none; start is ignored while busy, abort ends a transfer at the next clk edge without done.
module apbspi_sclk_ctrl #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] len,
  input  logic             cpol,
  input  logic             cpha,
  output logic             sclk,
  output logic             cs_n,
  output logic             sample_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  // Edge counter must reach 2*(len+1) = 2^(LEN_W+1) without wrapping.
  localparam int ECNT_W = LEN_W + 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_l_q, div_l_d;
  logic [LEN_W-1:0]    len_l_q, len_l_d;
  logic                cpol_l_q, cpol_l_d;
  logic                cpha_l_q, cpha_l_d;
  logic [DIV_W-1:0]    hcnt_q, hcnt_d;
  logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                sample_q, sample_d;
  logic                shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ECNT_W-1:0]   ecnt_nxt;
  logic [ECNT_W-1:0]   last_edge;
  logic                leading;

  // Edge bookkeeping: the edge about to happen, whether it is the last one, and its polarity.
  always_comb begin
    ecnt_nxt  = ecnt_q + ECNT_W'(1);
    last_edge = {1'b0, len_l_q, 1'b0} + ECNT_W'(2);
    leading   = ecnt_nxt[0];
  end

  // Next-state and registered-output logic; strobes and done default low so they are single-cycle.
  always_comb begin
    state_d  = state_q;
    div_l_d  = div_l_q;
    len_l_d  = len_l_q;
    cpol_l_d = cpol_l_q;
    cpha_l_d = cpha_l_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        // abort in the same cycle suppresses the start
        if (start && !abort) begin
          div_l_d  = div;
          len_l_d  = len;
          cpol_l_d = cpol;
          cpha_l_d = cpha;
          hcnt_d   = '0;
          ecnt_d   = '0;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // abort wins over a coincident SCLK edge: no strobes, no done
          state_d = IDLE;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          sclk_d  = cpol_l_q;
        end else if (hcnt_q == div_l_q) begin
          hcnt_d = '0;
          ecnt_d = ecnt_nxt;
          sclk_d = ~sclk_q;
          if (cpha_l_q) begin
            shift_d  = leading;
            sample_d = !leading;
          end else begin
            sample_d = leading;
            // no further bit to present after the final trailing edge
            shift_d  = !leading && (ecnt_nxt != last_edge);
          end
          if (ecnt_nxt == last_edge) begin
            // even toggle count leaves sclk back at cpol_l
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_l_q  <= '0;
      len_l_q  <= '0;
      cpol_l_q <= 1'b0;
      cpha_l_q <= 1'b0;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_l_q  <= div_l_d;
      len_l_q  <= len_l_d;
      cpol_l_q <= cpol_l_d;
      cpha_l_q <= cpha_l_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign sample_en = sample_q;
  assign shift_en  = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_apbspi_sclk_ctrl.sv
// Bench for apbspi_sclk_ctrl: expected waveforms come from a timing model indexed by cycles since start.
module tb_apbspi_sclk_ctrl;
  localparam int DIV_W = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [LEN_W-1:0] len = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic             sclk, cs_n, sample_en, shift_en, busy, done;

  int checks = 0;
  int failures = 0;

  apbspi_sclk_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .div(div), .len(len), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .cs_n(cs_n), .sample_en(sample_en), .shift_en(shift_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1);
  end

  // Expected {sclk, cs_n, sample_en, shift_en, busy, done} t cycles after the accepting edge.
  // Edges fall every (d+1) cycles; edge n is leading when n is odd; the transfer has 2*(l+1) edges.
  function automatic logic [5:0] model(int t, int d, int l, int po, int ph);
    int p, total, n;
    logic s, sm, sh;
    p = d + 1;
    total = p * 2 * (l + 1);
    if (t > total) return {po[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    if (t == total) return {po[0], 1'b1, ph[0], 1'b0, 1'b0, 1'b1};
    n = t / p;
    s = po[0] ^ (n % 2 == 1);
    sm = 1'b0;
    sh = 1'b0;
    if (t > 0 && t % p == 0) begin
      if (n % 2 == 1) begin
        sm = (ph == 0);
        sh = (ph == 1);
      end else begin
        sm = (ph == 1);
        sh = (ph == 0);
      end
    end
    return {s, 1'b0, sm, sh, 1'b1, 1'b0};
  endfunction

  function automatic int total_of(int d, int l);
    return (d + 1) * 2 * (l + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int d, int l, int po, int ph);
    div   = DIV_W'(d);
    len   = LEN_W'(l);
    cpol  = po[0];
    cpha  = ph[0];
    start = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst_n = 1'b0;
    cpol = 1'b1;
    step();
    step();
    obs = {sclk, cs_n, sample_en, shift_en, busy, done};
    checks++;
    if (obs !== 6'b010000) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", obs, 6'b010000);
    end
    rst_n = 1'b1;
    step();
    obs = {sclk, cs_n, sample_en, shift_en, busy, done};
    checks++;
    if (obs !== 6'b110000) begin
      failures++;
      $display("FAIL idle_tracks_cpol got=%b want=%b", obs, 6'b110000);
    end
    cpol = 1'b0;
    step();
  endtask

  task automatic test_basic_cpha0();
    logic [5:0] obs, exp;
    int total;
    total = total_of(1, 1);
    set_cfg(1, 1, 0, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 1, 1, 0, 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL basic_cpha0 t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_cpha1_cpol1();
    logic [5:0] obs, exp;
    int total;
    total = total_of(0, 2);
    set_cfg(0, 2, 1, 1);
    step();
    start = 1'b0;
    for (int t = 0; t <= total + 3; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 0, 2, 1, 1);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL cpha1_cpol1 t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_max_config();
    logic [5:0] obs, exp;
    int total, busy_cnt, done_cnt, bad;
    total = total_of(255, 31);
    busy_cnt = 0;
    done_cnt = 0;
    bad = 0;
    set_cfg(255, 31, 0, 1);
    step();
    start = 1'b0;
    for (int t = 0; t <= total + 2; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 255, 31, 0, 1);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      checks++;
      if (obs !== exp) begin
        failures++;
        bad++;
        if (bad < 10) $display("FAIL max_config t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    checks++;
    if (busy_cnt != 16384) begin
      failures++;
      $display("FAIL max_busy_cycles got=%0d want=%0d", busy_cnt, 16384);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL max_done_pulses got=%0d want=%0d", done_cnt, 1);
    end
  endtask

  task automatic test_ignored_start();
    logic [5:0] obs, exp;
    int total, total2, done_cnt;
    total = total_of(2, 3);
    total2 = total_of(1, 1);
    done_cnt = 0;
    set_cfg(2, 3, 0, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= total; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 2, 3, 0, 0);
      if (done === 1'b1) done_cnt++;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL ignored_start t=%0d got=%b want=%b", t, obs, exp);
      end
      if (t == 5) set_cfg(6, 0, 1, 1);
      if (t == 6) begin
        start = 1'b0;
        cpol = 1'b0;
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL ignored_start_done got=%0d want=%0d", done_cnt, 1);
    end
    // request lands on the cycle right after done
    set_cfg(1, 1, 1, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= total2 + 1; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 1, 1, 1, 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] obs, exp;
    int d, l, po, ph, total;
    for (int r = 0; r < 8; r++) begin
      d  = int'($urandom_range(0, 6));
      l  = int'($urandom_range(0, 7));
      po = int'($urandom_range(0, 1));
      ph = int'($urandom_range(0, 1));
      total = total_of(d, l);
      set_cfg(d, l, po, ph);
      step();
      start = 1'b0;
      for (int t = 0; t <= total + 1; t++) begin
        if (t > 0) step();
        obs = {sclk, cs_n, sample_en, shift_en, busy, done};
        exp = model(t, d, l, po, ph);
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL random r=%0d d=%0d l=%0d cpol=%0d cpha=%0d t=%0d got=%b want=%b",
                   r, d, l, po, ph, t, obs, exp);
        end
        if (t < total) begin
          // configuration churn while busy must not disturb the transfer
          div   = DIV_W'($urandom);
          len   = LEN_W'($urandom);
          cpol  = 1'($urandom);
          cpha  = 1'($urandom);
          start = 1'($urandom);
        end else begin
          start = 1'b0;
          cpol  = po[0];
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] obs, exp;
    int total, done_cnt;
    done_cnt = 0;
    // 8-bit transfer aborted right after its third edge
    set_cfg(1, 7, 1, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 1, 7, 1, 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort_pre t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    obs = {sclk, cs_n, sample_en, shift_en, busy, done};
    checks++;
    if (obs !== 6'b110000) begin
      failures++;
      $display("FAIL abort_exit got=%b want=%b", obs, 6'b110000);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL abort_quiet got=%0d want=%0d", done_cnt, 0);
    end
    // abort together with start in IDLE: start dropped
    set_cfg(0, 0, 1, 0);
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL abort_with_start busy=%b cs_n=%b want busy=0 cs_n=1", busy, cs_n);
    end
    // abort coincident with an SCLK edge (div=0 edges every cycle)
    set_cfg(0, 3, 0, 1);
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    obs = {sclk, cs_n, sample_en, shift_en, busy, done};
    checks++;
    if (obs !== 6'b010000) begin
      failures++;
      $display("FAIL abort_on_edge got=%b want=%b", obs, 6'b010000);
    end
    // a full transfer still runs after abort
    total = total_of(1, 7);
    set_cfg(1, 7, 1, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 1, 7, 1, 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL after_abort t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] obs, exp;
    int total;
    set_cfg(3, 4, 1, 1);
    step();
    start = 1'b0;
    for (int t = 1; t <= 10; t++) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_busy got=%b want=%b", busy, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {sclk, cs_n, sample_en, shift_en, busy, done};
    checks++;
    if (obs !== 6'b010000) begin
      failures++;
      $display("FAIL async_reset_immediate got=%b want=%b", obs, 6'b010000);
    end
    step();
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_hold done=%b busy=%b want 0 0", done, busy);
    end
    rst_n = 1'b1;
    step();
    total = total_of(2, 1);
    set_cfg(2, 1, 0, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      if (t > 0) step();
      obs = {sclk, cs_n, sample_en, shift_en, busy, done};
      exp = model(t, 2, 1, 0, 0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL after_reset t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_cpha0();
    test_cpha1_cpol1();
    test_max_config();
    test_ignored_start();
    test_random();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
